// File: rtl/tinymoa_nibble_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tinymoa_nibble_sequencer                                        |
// | Purpose  : Operand sequencer for the TinyMOA nibble-serial datapath.       |
// |            Accepts a full-width op on a valid/ready handshake, feeds the   |
// |            4-bit ALU one nibble per cycle (LS nibble first), chains the    |
// |            carry/compare flags between nibbles, assembles the result word |
// |            and offers it with the final flags on a second handshake.       |
// | Ports    : clk, rstn (async, active-low)                                   |
// |            start_valid/start_ready, opcode_in, a_in, b_in  - op intake     |
// |            alu_en, alu_opcode, alu_a, alu_b, alu_carry, alu_cmp - to ALU   |
// |            alu_result, alu_carry_in, alu_cmp_in            - from ALU      |
// |            result_valid/result_ready, result, carry_out, cmp_out - output  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tinymoa_nibble_sequencer #(
  parameter int NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [3:0]             opcode_in,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  output logic                   alu_en,
  output logic [3:0]             alu_opcode,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_carry,
  output logic                   alu_cmp,
  input  logic [3:0]             alu_result,
  input  logic                   alu_carry_in,
  input  logic                   alu_cmp_in,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   cmp_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res_sh;
  logic [W-1:0]  res_next;
  logic [CW-1:0] cnt;
  logic [3:0]    opcode_r;
  logic          carry_r;
  logic          cmp_r;

  // Result nibbles enter at the top and migrate down, so after NIBBLES
  // shifts the first (least-significant) nibble sits at bits [3:0].
  generate
    if (NIBBLES > 1) begin : g_res_multi
      assign res_next = {alu_result, res_sh[W-1:4]};
    end else begin : g_res_single
      assign res_next = alu_result;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      opcode_r <= '0;
      carry_r  <= 1'b0;
      cmp_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            opcode_r <= opcode_in;
            a_sh     <= a_in;
            b_sh     <= b_in;
            cnt      <= '0;
            // Subtract-class ops compute A + ~B + 1, so the chain starts
            // with carry set; compare starts "equal so far".
            carry_r  <= opcode_in[3];
            cmp_r    <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          res_sh  <= res_next;
          carry_r <= alu_carry_in;
          cmp_r   <= alu_cmp_in;
          if (cnt == LAST_NIB) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt   <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wire in_run  = (state == ST_RUN);
  wire in_done = (state == ST_DONE);

  assign start_ready  = (state == ST_IDLE);
  assign alu_en       = in_run;
  assign alu_opcode   = opcode_r;
  assign alu_a        = in_run ? a_sh[3:0] : 4'd0;
  assign alu_b        = in_run ? b_sh[3:0] : 4'd0;
  assign alu_carry    = in_run & carry_r;
  assign alu_cmp      = in_run & cmp_r;

  // Outputs are gated by DONE so stale flags never leak out in IDLE/RUN.
  assign result_valid = in_done;
  assign result       = in_done ? res_sh : '0;
  assign carry_out    = in_done & carry_r;
  assign cmp_out      = in_done & cmp_r;

endmodule
`default_nettype wire

// File: tb/tb_tinymoa_nibble_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tinymoa_nibble_sequencer                                     |
// | Purpose  : Self-checking bench for tinymoa_nibble_sequencer with a         |
// |            behavioural 4-bit ALU (0=ADD, 8=SUB as A+~B+c, 1=PASS-A).       |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tinymoa_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_valid;
  logic        start_ready;
  logic [3:0]  opcode_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        alu_en;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_carry;
  logic        alu_cmp;
  logic [3:0]  alu_result;
  logic        alu_carry_in;
  logic        alu_cmp_in;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        cmp_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tinymoa_nibble_sequencer #(.NIBBLES(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .opcode_in    (opcode_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .alu_en       (alu_en),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_carry    (alu_carry),
    .alu_cmp      (alu_cmp),
    .alu_result   (alu_result),
    .alu_carry_in (alu_carry_in),
    .alu_cmp_in   (alu_cmp_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .carry_out    (carry_out),
    .cmp_out      (cmp_out)
  );

  // Behavioural nibble ALU
  logic [4:0] sum;
  always_comb begin
    sum          = 5'd0;
    alu_result   = 4'd0;
    alu_carry_in = 1'b0;
    case (alu_opcode)
      4'd0: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_carry};
        alu_result   = sum[3:0];
        alu_carry_in = sum[4];
      end
      4'd8: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_carry};
        alu_result   = sum[3:0];
        alu_carry_in = sum[4];
      end
      4'd1: alu_result = alu_a;
      default: ;
    endcase
    alu_cmp_in = alu_cmp & (alu_a == alu_b);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        z;
    bit          nib;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assumes the DUT is in IDLE; runs one op with result_ready held low until DONE.
  task automatic run_op(input vec_t v);
    int lat;
    start_valid = 1'b1;
    opcode_in   = v.op;
    a_in        = v.a;
    b_in        = v.b;
    step();                                  // accepting edge
    start_valid = 1'b0;
    a_in        = $urandom;
    b_in        = $urandom;
    opcode_in   = 4'd15;
    lat = 0;
    while (!result_valid && lat < 20) begin
      if (v.nib) chk("nibble_order", {28'd0, alu_a}, lat);
      if (lat == 0) chk("first_carry", {31'd0, alu_carry}, {31'd0, v.op[3]});
      chk("alu_en_run", {31'd0, alu_en}, 32'd1);
      step();
      lat++;
    end
    chk("latency", lat, 32'd8);
    chk("result", result, v.res);
    chk("carry_out", {31'd0, carry_out}, {31'd0, v.c});
    chk("cmp_out", {31'd0, cmp_out}, {31'd0, v.z});
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("back_to_idle", {31'd0, start_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [31:0] acc_cyc[3];
    logic [31:0] b2b_a[3];
    logic [31:0] b2b_b[3];
    logic [31:0] b2b_r[3];
    int          w;

    //          op     a             b             result        c     z     nib
    vecs[0] = '{4'd1, 32'h76543210, 32'h00000000, 32'h76543210, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'd0, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'd8, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'd8, 32'h00000005, 32'h00000006, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'd0, 32'h89ABCDEF, 32'h12345678, 32'h9BE02467, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'd8, 32'h00000010, 32'h00000001, 32'h0000000F, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0};

    rstn = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    opcode_in = 4'd0; a_in = '0; b_in = '0;

    // Reset values, before any clock edge
    #3;
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, carry_out, cmp_out}, 32'd0);
    chk("rst_alu", {18'd0, alu_en, alu_opcode, alu_a, alu_b, alu_carry, alu_cmp}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i]);
    end

    // Backpressure: DONE held with start_valid asserted
    start_valid = 1'b1; opcode_in = 4'd0; a_in = 32'h11111111; b_in = 32'h22222222;
    step();
    start_valid = 1'b0;
    w = 0;
    while (!result_valid && w < 20) begin step(); w++; end
    chk("bp_reach_done", {31'd0, result_valid}, 32'd1);
    held = result;
    chk("bp_result", held, 32'h33333333);
    start_valid = 1'b1; opcode_in = 4'd8; a_in = 32'hDEADBEEF; b_in = 32'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_result", result, 32'h33333333);
      chk("bp_hold_flags", {29'd0, result_valid, carry_out, cmp_out}, 32'h4);
      chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
      chk("bp_no_latch", {28'd0, alu_opcode}, 32'd0);
    end
    result_ready = 1'b1; start_valid = 1'b0;
    step();
    result_ready = 1'b0;
    chk("bp_idle_after", {30'd0, start_ready, result_valid}, 32'h2);

    // Reset during the 4th RUN cycle
    start_valid = 1'b1; opcode_in = 4'd0; a_in = 32'h0000FFFF; b_in = 32'h00000001;
    step();
    start_valid = 1'b0;
    step(); step(); step();
    chk("mid_run_active", {31'd0, alu_en}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    run_op(vecs[7]);

    // Back-to-back with start_valid and result_ready tied high
    b2b_a[0] = 32'h00000001; b2b_b[0] = 32'h00000001; b2b_r[0] = 32'h00000002;
    b2b_a[1] = 32'h00000100; b2b_b[1] = 32'h000000FF; b2b_r[1] = 32'h000001FF;
    b2b_a[2] = 32'hFFFFFFF0; b2b_b[2] = 32'h00000010; b2b_r[2] = 32'h00000000;
    start_valid = 1'b1; result_ready = 1'b1; opcode_in = 4'd0;
    for (int i = 0; i < 3; i++) begin
      w = 0;
      while (!start_ready && w < 20) begin step(); w++; end
      chk("b2b_ready", {31'd0, start_ready}, 32'd1);
      acc_cyc[i] = cyc;
      a_in = b2b_a[i]; b_in = b2b_b[i];
      step();
      w = 0;
      while (!result_valid && w < 20) begin step(); w++; end
      chk("b2b_result", result, b2b_r[i]);
      step();
    end
    chk("b2b_spacing_1", acc_cyc[1] - acc_cyc[0], 32'd10);
    chk("b2b_spacing_2", acc_cyc[2] - acc_cyc[1], 32'd10);
    start_valid = 1'b0; result_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
